// File: rtl/md_unit_ex.sv
// md_unit_ex: EX-stage multi-cycle multiply/divide unit owning the HI/LO registers
module md_unit_ex #(
   parameter int MULT_CYCLES = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StartE,
   input  logic [1:0]  MdOpE,
   input  logic [31:0] SrcAE,
   input  logic [31:0] SrcBE,
   input  logic        HiLoWriteE,
   input  logic        HiLoE,
   output logic [31:0] HiLoOutE,
   output logic        BusyE,
   output logic        StallMdE,
   output logic        DoneE
);
   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
   state_t      state;
   logic [31:0] hi, lo, q, r, d, a_orig, a_abs, b_abs, r_next, q_next;
   logic [63:0] prod, ax, bx;
   logic [32:0] t;
   logic [4:0]  cnt;
   logic        qs, rs, dz, fin, done, ge;
   // operand conditioning and one restoring-division step (MdOpE[0] selects unsigned)
   always_comb begin
      ax     = MdOpE[0] ? {32'b0, SrcAE} : {{32{SrcAE[31]}}, SrcAE};
      bx     = MdOpE[0] ? {32'b0, SrcBE} : {{32{SrcBE[31]}}, SrcBE};
      a_abs  = (!MdOpE[0] && SrcAE[31]) ? -SrcAE : SrcAE;
      b_abs  = (!MdOpE[0] && SrcBE[31]) ? -SrcBE : SrcBE;
      t      = {r, q[31]};
      ge     = t >= {1'b0, d};
      r_next = ge ? 32'(t - {1'b0, d}) : t[31:0];
      q_next = {q[30:0], ge};
   end
   // HI/LO ownership, operation sequencing and commit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         hi     <= '0;
         lo     <= '0;
         q      <= '0;
         r      <= '0;
         d      <= '0;
         a_orig <= '0;
         prod   <= '0;
         cnt    <= '0;
         qs     <= 1'b0;
         rs     <= 1'b0;
         dz     <= 1'b0;
         fin    <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (HiLoWriteE) begin
            if (HiLoE) hi <= SrcAE;
            else lo <= SrcAE;
            state <= IDLE;
         end else begin
            case (state)
               IDLE: if (StartE) begin
                  if (MdOpE[1]) begin
                     q      <= a_abs;
                     r      <= '0;
                     d      <= b_abs;
                     a_orig <= SrcAE;
                     qs     <= !MdOpE[0] && (SrcAE[31] ^ SrcBE[31]);
                     rs     <= !MdOpE[0] && SrcAE[31];
                     dz     <= SrcBE == 32'b0;
                     fin    <= 1'b0;
                     cnt    <= 5'd31;
                     state  <= DIV;
                  end else begin
                     prod  <= ax * bx;
                     cnt   <= 5'(MULT_CYCLES - 1);
                     state <= MUL;
                  end
               end
               MUL: if (cnt == 5'd0) begin
                  hi    <= prod[63:32];
                  lo    <= prod[31:0];
                  done  <= 1'b1;
                  state <= IDLE;
               end else cnt <= cnt - 5'd1;
               DIV: if (fin) begin
                  lo    <= dz ? 32'hFFFF_FFFF : (qs ? -q : q);
                  hi    <= dz ? a_orig : (rs ? -r : r);
                  done  <= 1'b1;
                  state <= IDLE;
               end else begin
                  q <= q_next;
                  r <= r_next;
                  if (cnt == 5'd0) fin <= 1'b1;
                  else cnt <= cnt - 5'd1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
   assign HiLoOutE = HiLoE ? hi : lo;
   assign BusyE    = state != IDLE;
   assign StallMdE = StartE | BusyE;
   assign DoneE    = done;
endmodule
